// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : PS/2 mouse command/response bytes and init-sequencer state type.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Host-to-mouse command bytes
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  // Mouse-to-host response bytes
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ERROR    = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_MOUSE_ID = 8'h00;

  typedef enum logic [3:0] {
    SEND_RST,
    ACK_RST,
    WAIT_BAT,
    WAIT_ID,
    SEND_RATE,
    ACK_RATE,
    SEND_VAL,
    ACK_VAL,
    SEND_EN,
    ACK_EN,
    STREAM,
    FAULT
  } mouse_init_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_mouse_init_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_mouse_init_sequencer_if
// Brief    : Byte-level handshake between the init sequencer and the PS/2
//            transceiver (command out, received bytes in).
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_mouse_init_sequencer_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       cmd_done;
  logic [7:0] command;
  logic       command_send;

  // Sequencer side: issues commands, consumes received bytes
  modport master (
    input  rx_byte,
    input  rx_valid,
    input  cmd_done,
    output command,
    output command_send
  );

  // Transceiver side
  modport slave (
    output rx_byte,
    output rx_valid,
    output cmd_done,
    input  command,
    input  command_send
  );
endinterface
`default_nettype wire

// File: rtl/ps2_packet_counter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_packet_counter
// Brief    : Tracks the position of stream bytes within 3-byte mouse packets,
//            resynchronising on the always-one bit 3 of the first byte.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_packet_counter (
  input  wire logic       PS2_CLK,
  input  wire logic       reset,
  input  wire logic       enable,
  input  wire logic       rx_valid,
  input  wire logic       sync_bit,
  output logic [2:0]      packet_number,
  output logic            packet_strobe
);

  // Count accepted bytes 1..3; outside STREAM the counter is held at zero
  always_ff @(posedge PS2_CLK) begin
    if (reset || !enable) begin
      packet_number <= 3'd0;
      packet_strobe <= 1'b0;
    end else begin
      packet_strobe <= 1'b0;
      if (rx_valid) begin
        if (packet_number == 3'd0 || packet_number == 3'd3) begin
          // Expecting byte 1: a clear bit 3 means we are misaligned, drop it
          if (sync_bit) begin
            packet_number <= 3'd1;
          end
        end else begin
          packet_number <= packet_number + 3'd1;
          packet_strobe <= (packet_number == 3'd2);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_mouse_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_mouse_init_sequencer
// Brief    : Brings a PS/2 mouse from power-up into stream mode (reset, BAT,
//            ID, set sample rate, enable), retrying the whole sequence on
//            protocol errors, then counts incoming packet bytes.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_init_sequencer
  import ps2_pkg::*;
#(
  parameter logic [7:0] SAMPLE_RATE = 8'd100,
  parameter int         MAX_RETRIES = 3
) (
  input  wire logic                  PS2_CLK,
  input  wire logic                  reset,
  ps2_mouse_init_sequencer_if.master bus,
  output logic                       mouse_enabled,
  output logic                       init_fault,
  output logic [2:0]                 packet_number,
  output logic                       packet_strobe
);

  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  mouse_init_state_t    state;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [7:0]           command_byte;
  logic                 send_req;

  // Per-state decode: byte to send, where each state goes next
  logic [7:0]           send_value;
  mouse_init_state_t    ack_state;
  logic [7:0]           expected_rsp;
  mouse_init_state_t    advance_state;
  mouse_init_state_t    resend_state;
  logic                 is_ack;

  assign bus.command      = command_byte;
  assign bus.command_send = send_req;

  // Static tables for the command/response phases of each state
  always_comb begin
    send_value    = CMD_RESET;
    ack_state     = ACK_RST;
    expected_rsp  = RSP_ACK;
    advance_state = WAIT_BAT;
    resend_state  = SEND_RST;
    is_ack        = 1'b0;
    case (state)
      SEND_RATE: begin send_value = CMD_SET_RATE; ack_state = ACK_RATE; end
      SEND_VAL:  begin send_value = SAMPLE_RATE;  ack_state = ACK_VAL;  end
      SEND_EN:   begin send_value = CMD_ENABLE;   ack_state = ACK_EN;   end
      ACK_RST:   begin advance_state = WAIT_BAT;  resend_state = SEND_RST;  is_ack = 1'b1; end
      WAIT_BAT:  begin expected_rsp = RSP_BAT_OK;   advance_state = WAIT_ID;   end
      WAIT_ID:   begin expected_rsp = RSP_MOUSE_ID; advance_state = SEND_RATE; end
      ACK_RATE:  begin advance_state = SEND_VAL;  resend_state = SEND_RATE; is_ack = 1'b1; end
      ACK_VAL:   begin advance_state = SEND_EN;   resend_state = SEND_VAL;  is_ack = 1'b1; end
      ACK_EN:    begin advance_state = STREAM;    resend_state = SEND_EN;   is_ack = 1'b1; end
      default:   ;
    endcase
  end

  // Init sequencer FSM with registered command/status outputs
  always_ff @(posedge PS2_CLK) begin
    if (reset) begin
      state         <= SEND_RST;
      retry_cnt     <= '0;
      command_byte  <= 8'h00;
      send_req      <= 1'b0;
      mouse_enabled <= 1'b0;
      init_fault    <= 1'b0;
    end else begin
      case (state)
        SEND_RST, SEND_RATE, SEND_VAL, SEND_EN: begin
          // Completion only counts once our request is actually on the bus;
          // received bytes are ignored while transmitting
          if (send_req && bus.cmd_done) begin
            send_req <= 1'b0;
            state    <= ack_state;
          end else begin
            command_byte <= send_value;
            send_req     <= 1'b1;
          end
        end
        ACK_RST, WAIT_BAT, WAIT_ID, ACK_RATE, ACK_VAL, ACK_EN: begin
          if (bus.rx_valid) begin
            if (bus.rx_byte == expected_rsp) begin
              state <= advance_state;
              if (advance_state == STREAM) begin
                mouse_enabled <= 1'b1;
                retry_cnt     <= '0;
              end
            end else if (is_ack && bus.rx_byte == RSP_RESEND) begin
              state <= resend_state;
            end else if (retry_cnt < RETRY_LIMIT) begin
              retry_cnt <= retry_cnt + RETRY_W'(1);
              state     <= SEND_RST;
            end else begin
              state      <= FAULT;
              init_fault <= 1'b1;
            end
          end
        end
        STREAM: ;
        FAULT: begin
          send_req   <= 1'b0;
          init_fault <= 1'b1;
        end
        default: state <= SEND_RST;
      endcase
    end
  end

  ps2_packet_counter u_packet_counter (
    .PS2_CLK       (PS2_CLK),
    .reset         (reset),
    .enable        (state == STREAM),
    .rx_valid      (bus.rx_valid),
    .sync_bit      (bus.rx_byte[3]),
    .packet_number (packet_number),
    .packet_strobe (packet_strobe)
  );

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_mouse_init_sequencer
// Brief    : Directed self-checking bench for the PS/2 mouse init sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_init_sequencer;

  logic       PS2_CLK = 1'b0;
  logic       reset   = 1'b1;
  logic       mouse_enabled;
  logic       init_fault;
  logic [2:0] packet_number;
  logic       packet_strobe;

  int n_vec = 0;
  int n_err = 0;

  ps2_mouse_init_sequencer_if bus();

  ps2_mouse_init_sequencer #(
    .SAMPLE_RATE (8'd100),
    .MAX_RETRIES (3)
  ) dut (
    .PS2_CLK       (PS2_CLK),
    .reset         (reset),
    .bus           (bus),
    .mouse_enabled (mouse_enabled),
    .init_fault    (init_fault),
    .packet_number (packet_number),
    .packet_strobe (packet_strobe)
  );

  always #5 PS2_CLK = ~PS2_CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PS2_CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd"},    bus.command, 8'h00);
    chk({tag, "_send"},   8'(bus.command_send), 8'h00);
    chk({tag, "_en"},     8'(mouse_enabled), 8'h00);
    chk({tag, "_fault"},  8'(init_fault), 8'h00);
    chk({tag, "_pn"},     8'(packet_number), 8'h00);
    chk({tag, "_strb"},   8'(packet_strobe), 8'h00);
    chk({tag, "_retry"},  8'(dut.retry_cnt), 8'h00);
    chk({tag, "_state"},  8'(dut.state), 8'h00);
  endtask

  // Wait (bounded) for a transmit request, check the byte, complete it
  task automatic do_send(input string tag, input logic [7:0] exp, input bit with_rx);
    int k = 0;
    while (bus.command_send !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_req"}, 8'(bus.command_send), 8'h01);
    chk({tag, "_cmd"}, bus.command, exp);
    bus.cmd_done = 1'b1;
    if (with_rx) begin
      bus.rx_valid = 1'b1;
      bus.rx_byte  = 8'hFC;
    end
    tick();
    bus.cmd_done = 1'b0;
    bus.rx_valid = 1'b0;
    chk({tag, "_drop"}, 8'(bus.command_send), 8'h00);
  endtask

  task automatic respond(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic init_seq(input bit resend_rate);
    do_send("rst", 8'hFF, 1'b0);
    respond(8'hFA);
    respond(8'hAA);
    respond(8'h00);
    do_send("rate", 8'hF3, 1'b0);
    if (resend_rate) begin
      respond(8'hFE);
      chk("resend_retry", 8'(dut.retry_cnt), 8'h00);
      do_send("rate_again", 8'hF3, 1'b1);
    end
    respond(8'hFA);
    do_send("val", 8'h64, 1'b0);
    respond(8'hFA);
    do_send("en", 8'hF4, 1'b0);
    respond(8'hFA);
    chk("enabled", 8'(mouse_enabled), 8'h01);
    chk("enter_pn", 8'(packet_number), 8'h00);
    chk("enter_retry", 8'(dut.retry_cnt), 8'h00);
  endtask

  task automatic stream_byte(input string tag, input logic [7:0] b,
                             input logic [2:0] epn, input logic estrb);
    respond(b);
    chk({tag, "_pn"}, 8'(packet_number), 8'(epn));
    chk({tag, "_strb"}, 8'(packet_strobe), 8'(estrb));
  endtask

  initial begin
    bus.rx_byte  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.cmd_done = 1'b0;

    // Reset values
    reset = 1'b1;
    tick();
    tick();
    chk_idle("reset");
    reset = 1'b0;

    // Nominal init followed by two full packets
    init_seq(1'b0);
    stream_byte("s1", 8'h08, 3'd1, 1'b0);
    stream_byte("s2", 8'h05, 3'd2, 1'b0);
    stream_byte("s3", 8'h03, 3'd3, 1'b1);
    stream_byte("s4", 8'h09, 3'd1, 1'b0);
    stream_byte("s5", 8'h00, 3'd2, 1'b0);
    stream_byte("s6", 8'h00, 3'd3, 1'b1);
    tick();
    chk("s_strb_low", 8'(packet_strobe), 8'h00);

    // Resend during set-rate, then resynchronisation in stream
    reset = 1'b1;
    tick();
    chk_idle("reset2");
    reset = 1'b0;
    init_seq(1'b1);
    stream_byte("r0", 8'h00, 3'd0, 1'b0);
    stream_byte("r1", 8'h08, 3'd1, 1'b0);
    stream_byte("r2", 8'h01, 3'd2, 1'b0);
    stream_byte("r3", 8'h01, 3'd3, 1'b1);

    // Reset in the middle of a packet
    reset = 1'b1;
    tick();
    chk_idle("reset3");
    reset = 1'b0;
    init_seq(1'b0);
    stream_byte("m1", 8'h08, 3'd1, 1'b0);
    stream_byte("m2", 8'h05, 3'd2, 1'b0);
    reset = 1'b1;
    tick();
    chk_idle("reset_mid");
    reset = 1'b0;
    tick();
    chk("restart_cmd", bus.command, 8'hFF);
    chk("restart_send", 8'(bus.command_send), 8'h01);

    // Error responses exhaust the retries and end in FAULT
    for (int i = 0; i < 4; i++) begin
      do_send("err_rst", 8'hFF, 1'b0);
      respond(8'hFC);
      chk("err_retry", 8'(dut.retry_cnt), 8'((i < 3) ? i + 1 : 3));
    end
    chk("fault", 8'(init_fault), 8'h01);
    chk("fault_send", 8'(bus.command_send), 8'h00);
    chk("fault_en", 8'(mouse_enabled), 8'h00);
    respond(8'hFA);
    tick();
    tick();
    chk("fault_hold", 8'(init_fault), 8'h01);
    chk("fault_state", 8'(dut.state), 8'd11);
    chk("fault_hold_send", 8'(bus.command_send), 8'h00);
    reset = 1'b1;
    tick();
    chk_idle("reset_fault");
    reset = 1'b0;
    tick();
    chk("after_fault_cmd", bus.command, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
